// File: rtl/cache_types_pkg.sv
// cache_types_pkg: shared sizing and types for the cache completion path.
//   NUM_BANKS, UUID_SIZE, BANKS_LEN, CMPL_FIFO_DEPTH : default geometry
//   cmpl_resp_t : one response beat {uuid, bank}
//   sat_add8    : 8-bit saturating add used by the drop counter
package cache_types_pkg;
   localparam int NUM_BANKS       = 4;
   localparam int UUID_SIZE       = 4;
   localparam int BANKS_LEN       = $clog2(NUM_BANKS);
   localparam int CMPL_FIFO_DEPTH = 4;

   typedef struct packed {
      logic [UUID_SIZE-1:0] uuid;
      logic [BANKS_LEN-1:0] bank;
   } cmpl_resp_t;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [8:0] b);
      logic [9:0] s;
      s = {2'b00, a} + {1'b0, b};
      return (s > 10'd255) ? 8'hFF : s[7:0];
   endfunction
endpackage

// File: rtl/cache_completion_arbiter_if.sv
// cache_completion_arbiter_if: bank completion pulses in, scheduler response out.
//   master : bank array / scheduler side (drives pulses and resp_ready)
//   slave  : the arbiter (drives response, backpressure and drop stats)
interface cache_completion_arbiter_if #(
   parameter int NUM_BANKS = cache_types_pkg::NUM_BANKS,
   parameter int UUID_SIZE = cache_types_pkg::UUID_SIZE,
   parameter int BANKS_LEN = $clog2(NUM_BANKS)
);
   logic [NUM_BANKS-1:0]                block_status;
   logic [NUM_BANKS-1:0][UUID_SIZE-1:0] uuid_block;
   logic                                resp_ready;
   logic                                resp_valid;
   logic [UUID_SIZE-1:0]                resp_uuid;
   logic [BANKS_LEN-1:0]                resp_bank;
   logic [NUM_BANKS-1:0]                bank_full;
   logic                                overflow;
   logic [7:0]                          drop_count;

   modport master (
      output block_status, uuid_block, resp_ready,
      input  resp_valid, resp_uuid, resp_bank, bank_full, overflow, drop_count
   );
   modport slave (
      input  block_status, uuid_block, resp_ready,
      output resp_valid, resp_uuid, resp_bank, bank_full, overflow, drop_count
   );
endinterface

// File: rtl/cache_uuid_fifo.sv
// cache_uuid_fifo: per-bank UUID FIFO with synchronous push/pop.
//   push/din    : enqueue; accepted when not full, or when full and popping
//   pop         : dequeue head; ignored when empty
//   empty/full  : occupancy flags from the registered count
//   almost_full : registered, high when next occupancy >= DEPTH-1
//   count/head  : occupancy and oldest entry
module cache_uuid_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             empty,
   output logic             full,
   output logic             almost_full,
   output logic [AW:0]      count,
   output logic [WIDTH-1:0] head
);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_LVL   = (AW+1)'(DEPTH-1);

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [AW-1:0]               rd_ptr, wr_ptr;
   logic [AW:0]                 count_nxt;
   logic                        do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_LVL);
   assign do_pop  = pop && !empty;
   // a full FIFO still takes a push when its head leaves in the same cycle
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)      count_nxt = count + 1'b1;
      else if (!do_push && do_pop) count_nxt = count - 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         almost_full <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count       <= count_nxt;
         almost_full <= (count_nxt >= AF_LVL);
      end
   end

   // storage needs no reset: it is only observed through a non-zero count
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/cache_completion_arbiter.sv
// cache_completion_arbiter: captures per-bank completion pulses into FIFOs and
// round-robins them onto a single valid/ready response channel.
//   CLK, nRST : clock, async active-low reset
//   bus       : slave side of cache_completion_arbiter_if (pulses in, response,
//               bank_full backpressure, overflow flag and drop_count out)
module cache_completion_arbiter #(
   parameter  int NUM_BANKS  = cache_types_pkg::NUM_BANKS,
   parameter  int UUID_SIZE  = cache_types_pkg::UUID_SIZE,
   parameter  int FIFO_DEPTH = cache_types_pkg::CMPL_FIFO_DEPTH,
   localparam int BANKS_LEN  = $clog2(NUM_BANKS),
   localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input logic                        CLK,
   input logic                        nRST,
   cache_completion_arbiter_if.slave  bus
);
   import cache_types_pkg::*;

   logic [NUM_BANKS-1:0]                empty, full, afull, pop, drop;
   logic [NUM_BANKS-1:0][CW-1:0]        cnt;
   logic [NUM_BANKS-1:0][UUID_SIZE-1:0] head;
   logic [BANKS_LEN-1:0]                rr_ptr, scan_grant, grant, hold_bank;
   logic                                hold_vld, any, xfer, overflow_q;
   logic [7:0]                          drop_count_q;
   logic [8:0]                          ndrop;

   genvar g;
   generate
      for (g = 0; g < NUM_BANKS; g++) begin : g_bank
         cache_uuid_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UUID_SIZE)) u_fifo (
            .CLK         (CLK),
            .nRST        (nRST),
            .push        (bus.block_status[g]),
            .pop         (pop[g]),
            .din         (bus.uuid_block[g]),
            .empty       (empty[g]),
            .full        (full[g]),
            .almost_full (afull[g]),
            .count       (cnt[g]),
            .head        (head[g])
         );
         assign drop[g] = bus.block_status[g] && full[g] && !pop[g];
      end
   endgenerate

   // occupancy is exported by the FIFO for debug; the arbiter only needs flags
   logic unused_cnt;
   assign unused_cnt = ^cnt;

   // first non-empty bank at or after rr_ptr; descending scan so the
   // smallest offset wins
   always_comb begin
      logic [BANKS_LEN-1:0] idx;
      idx        = '0;
      scan_grant = rr_ptr;
      for (int k = NUM_BANKS-1; k >= 0; k--) begin
         idx = rr_ptr + BANKS_LEN'(k);
         if (!empty[idx]) scan_grant = idx;
      end
   end

   // a presented-but-unaccepted grant is frozen so late pushes into a
   // higher-priority bank cannot change the beat under the scheduler
   assign any   = ~&empty;
   assign grant = hold_vld ? hold_bank : scan_grant;
   assign xfer  = any && bus.resp_ready;

   always_comb begin
      pop = '0;
      if (xfer) pop[grant] = 1'b1;
   end

   always_comb begin
      ndrop = '0;
      for (int i = 0; i < NUM_BANKS; i++) ndrop = ndrop + 9'(drop[i]);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rr_ptr       <= '0;
         hold_vld     <= 1'b0;
         hold_bank    <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         if (xfer) rr_ptr <= grant + 1'b1;
         hold_vld  <= any && !bus.resp_ready;
         hold_bank <= grant;
         if (|drop) overflow_q <= 1'b1;
         drop_count_q <= sat_add8(drop_count_q, ndrop);
      end
   end

   assign bus.resp_valid = any;
   assign bus.resp_bank  = any ? grant : '0;
   assign bus.resp_uuid  = any ? head[grant] : '0;
   assign bus.bank_full  = afull;
   assign bus.overflow   = overflow_q;
   assign bus.drop_count = drop_count_q;
endmodule

// File: doc/cache_completion_arbiter.md
# cache_completion_arbiter

Downstream of the lockup-free cache's bank array. Each cycle, every cache bank can raise a single-cycle completion pulse carrying the UUID of a finished miss. This block captures those pulses into per-bank FIFOs and arbitrates them round-robin onto one valid/ready response channel to the scheduler. It also reports per-bank FIFO occupancy as backpressure and counts any dropped completions.

## Interface
- NUM_BANKS, default 4: number of cache banks; power of two, at least 2.
- UUID_SIZE, default 4: UUID width in bits.
- FIFO_DEPTH, default 4: entries per bank FIFO; power of two, at least 2.

- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- block_status  in  NUM_BANKS  per-bank completion pulse, one cycle wide.
- uuid_block  in  NUM_BANKS x UUID_SIZE  UUID paired with each block_status bit.
- resp_ready  in  1  scheduler accepts the response this cycle.
- resp_valid  out  1  a response is presented.
- resp_uuid  out  UUID_SIZE  UUID of the presented response.
- resp_bank  out  BANKS_LEN  bank index of the presented response.
- bank_full  out  NUM_BANKS  registered; bit i is high when FIFO i holds FIFO_DEPTH or FIFO_DEPTH-1 entries. Upstream stalls new misses to that bank.
- overflow  out  1  sticky flag; set when a completion is dropped.
- drop_count  out  8  saturating count of dropped completions.

## Operation
- Push: block_status[i] high pushes uuid_block[i] into FIFO i. All banks can push in the same cycle.
- Arbitration:
  - rr_ptr has width BANKS_LEN and resets to 0.
  - The grant goes to the first non-empty FIFO scanning rr_ptr, rr_ptr+1, … modulo NUM_BANKS.
  - resp_valid = any FIFO non-empty.
  - resp_uuid and resp_bank come from the granted FIFO head.
  - When no FIFO is non-empty, resp_uuid and resp_bank are driven to 0.
- Transfer occurs when resp_valid && resp_ready. On a transfer:
  - the granted FIFO pops;
  - rr_ptr becomes grant+1, wrapping modulo NUM_BANKS.
  - With no transfer, rr_ptr holds.
- Handshake: while resp_valid is high and resp_ready is low, resp_uuid and resp_bank must not change, even if a new push lands in a higher-priority bank. The grant is latched and held until transfer.
- Full FIFO:
  - A push with no pop on the same cycle is dropped.
  - On a drop, overflow is set and drop_count increments, saturating at 255.
  - Multiple banks dropping in one cycle add the number of dropped completions, saturating.
- Simultaneous push and pop on a full FIFO is accepted; occupancy is unchanged.
- Pointer and count rules:
  - Read and write pointers have width log2(FIFO_DEPTH) and wrap naturally.
  - Occupancy has width log2(FIFO_DEPTH)+1.
- Reset (asynchronous, including mid-transfer) clears:
  - all FIFOs, pointers and rr_ptr;
  - the held grant;
  - overflow and drop_count.
  - Pending completions are lost.
- Reset values: resp_valid=0, resp_uuid=0, resp_bank=0, bank_full=0, overflow=0, drop_count=0.

## Timing
- A push at edge N is visible on resp_valid from cycle N+1. There is no same-cycle bypass.
- The response outputs are combinational from registered FIFO heads, rr_ptr and the grant hold. There is no combinational path from block_status or resp_ready to any output.
- Throughput is one response per cycle with resp_ready held high.
- bank_full is registered from next-state occupancy, so it is valid the cycle after the push that fills the FIFO. The almost-full threshold covers the one-cycle upstream stall latency.
- overflow and drop_count update at the edge where the drop occurs.

## Structure
- Add to cache_types_pkg: NUM_BANKS, UUID_SIZE, BANKS_LEN, CMPL_FIFO_DEPTH, and typedef cmpl_resp_t {uuid, bank}.
- Sub-module cache_uuid_fifo, instantiated NUM_BANKS times:
  - synchronous push/pop;
  - outputs empty, full, almost_full, count and head.
- The top level holds the round-robin arbiter, grant-hold register and drop accounting.

## Test plan
- Single completion: block_status=4'b0100 with uuid 4'hA, resp_ready=1.
  - Next cycle: resp_valid=1, resp_uuid=A, resp_bank=2.
  - The cycle after: resp_valid=0, rr_ptr=3.
- Four-bank burst in one cycle with UUIDs 1,2,3,4 and rr_ptr=0, resp_ready=1: responses appear on consecutive cycles in bank order 0,1,2,3.
- Stall hold: bank 3 holds UUID 7 with resp_ready=0; bank 0 then pushes UUID 5. Output stays bank 3 / UUID 7 until resp_ready=1, then bank 0 / UUID 5.
- Overflow: five pushes to bank 1 with resp_ready=0 and FIFO_DEPTH=4.
  - bank_full[1]=1 after the 3rd push.
  - The 5th push is dropped: overflow=1, drop_count=1.
  - Draining returns only the first four UUIDs, in order.
- Full-FIFO push plus pop: bank 0 full, resp_ready=1, push on the same cycle. No drop; occupancy stays 4.
- Asynchronous reset asserted mid-burst, between clock edges: all outputs go to 0 immediately. After release, no stale response appears.
